// File: rtl/div.sv
// div: multi-cycle signed/unsigned divider (restoring trial subtraction,
// one quotient bit per cycle) that sits downstream of the EX stage.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = div (two's complement), 0 = divu
//   opdata1_i     dividend, sampled only when a division is accepted
//   opdata2_i     divisor, sampled only when a division is accepted
//   start_i       request; held high by EX until it has consumed the result
//   annul_i       abort the current division (pipeline flush)
//   result_o      {remainder, quotient}, maps to {HI, LO}
//   ready_o       result_o valid
module div #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [2*DATA_W:0]   dvd, dvd_nxt;      // {partial remainder, dividend/quotient, pad}
    logic [DATA_W-1:0]   dsr, dsr_nxt;      // divisor magnitude
    logic                neg_quo, neg_quo_nxt;
    logic                neg_rem, neg_rem_nxt;
    logic [2*DATA_W-1:0] result_nxt;
    logic                ready_nxt;

    logic [DATA_W-1:0]   mag1, mag2, quo, rem;
    logic [DATA_W:0]     trial;
    logic                sgn1, sgn2;

    assign sgn1 = signed_div_i & opdata1_i[DATA_W-1];
    assign sgn2 = signed_div_i & opdata2_i[DATA_W-1];
    assign mag1 = sgn1 ? ~opdata1_i + 1'b1 : opdata1_i;
    assign mag2 = sgn2 ? ~opdata2_i + 1'b1 : opdata2_i;

    // Borrow out of the extra MSB means the divisor did not fit this step.
    assign trial = {1'b0, dvd[2*DATA_W-1:DATA_W]} - {1'b0, dsr};

    assign quo = neg_quo ? ~dvd[DATA_W-1:0] + 1'b1 : dvd[DATA_W-1:0];
    // Remainder follows the sign of the dividend.
    assign rem = neg_rem ? ~dvd[2*DATA_W:DATA_W+1] + 1'b1 : dvd[2*DATA_W:DATA_W+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            dvd      <= '0;
            dsr      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dvd      <= dvd_nxt;
            dsr      <= dsr_nxt;
            neg_quo  <= neg_quo_nxt;
            neg_rem  <= neg_rem_nxt;
            result_o <= result_nxt;
            ready_o  <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        dvd_nxt     = dvd;
        dsr_nxt     = dsr;
        neg_quo_nxt = neg_quo;
        neg_rem_nxt = neg_rem;
        result_nxt  = result_o;
        ready_nxt   = ready_o;

        case (state)
            FREE: begin
                ready_nxt  = 1'b0;
                result_nxt = '0;
                if (start_i && !annul_i) begin
                    cnt_nxt = '0;
                    if (opdata2_i == '0) begin
                        state_nxt = BYZERO;
                    end else begin
                        state_nxt   = ON;
                        // First shift is folded in by the trailing pad bit.
                        dvd_nxt     = {{DATA_W{1'b0}}, mag1, 1'b0};
                        dsr_nxt     = mag2;
                        neg_quo_nxt = sgn1 ^ sgn2;
                        neg_rem_nxt = sgn1;
                    end
                end
            end
            BYZERO: begin
                // Two cycles here so a zero divisor reports ready two edges
                // after the request is sampled.
                if (annul_i) begin
                    state_nxt = FREE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    cnt_nxt = CNT_W'(1);
                end else begin
                    state_nxt  = END;
                    cnt_nxt    = '0;
                    result_nxt = '0;
                    ready_nxt  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_nxt  = FREE;
                    cnt_nxt    = '0;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end else if (cnt != CNT_W'(DATA_W)) begin
                    if (trial[DATA_W])
                        dvd_nxt = {dvd[2*DATA_W-1:0], 1'b0};
                    else
                        dvd_nxt = {trial[DATA_W-1:0], dvd[DATA_W-1:0], 1'b1};
                    cnt_nxt = cnt + 1'b1;
                end else begin
                    state_nxt  = END;
                    cnt_nxt    = '0;
                    result_nxt = {rem, quo};
                    ready_nxt  = 1'b1;
                end
            end
            END: begin
                if (!start_i || annul_i) begin
                    state_nxt  = FREE;
                    result_nxt = '0;
                    ready_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = FREE;
            end
        endcase
    end
endmodule
